// File: rtl/debounce_ctrl.sv
// Debounce control FSM for one channel: synchronises noisy_in, sequences an external timer, emits a clean level and edge pulses.
// Latency: SYNC_STAGES cycles to the synchroniser output, +1 to enter WAIT, timer interval to timer_done, +1 to debounced_out.
// Backpressure: none; the FSM advances every clock, and timer_done outside the WAIT states is ignored.
module debounce_ctrl #(
  parameter int   SYNC_STAGES  = 2,
  parameter logic INIT_LEVEL   = 1'b0,
  parameter int   GLITCH_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    noisy_in,
  input  logic                    timer_done,
  input  logic                    glitch_clr,
  output logic                    timer_en,
  output logic                    debounced_out,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam state_t                    RST_STATE = INIT_LEVEL ? STABLE_HIGH : STABLE_LOW;
  localparam logic [GLITCH_CNT_W-1:0] GCNT_ONE  = GLITCH_CNT_W'(1);
  localparam logic [GLITCH_CNT_W-1:0] GCNT_MAX  = '1;

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  state_t                  state_q, state_d;
  logic                    timer_en_q, timer_en_d;
  logic                    deb_q, deb_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [GLITCH_CNT_W-1:0] gcnt_q, gcnt_d;
  logic                    s;
  logic                    glitch_evt;

  // The FSM only ever looks at the last synchroniser stage.
  assign s = sync_q[SYNC_STAGES-1];

  // Next-state, output and glitch-counter decode; a revert in a WAIT state beats a same-cycle timer_done.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], noisy_in};
    state_d    = state_q;
    deb_d      = deb_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_evt = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d    = STABLE_LOW;
          glitch_evt = 1'b1;
        end else if (timer_done) begin
          state_d = STABLE_HIGH;
          deb_d   = 1'b1;
          rise_d  = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (s) begin
          state_d    = STABLE_HIGH;
          glitch_evt = 1'b1;
        end else if (timer_done) begin
          state_d = STABLE_LOW;
          deb_d   = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
    // Registering the decode of the next state makes timer_en a pure function of the state register.
    timer_en_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (glitch_evt && (gcnt_q != GCNT_MAX)) begin
      gcnt_d = gcnt_q + GCNT_ONE;
    end else begin
      gcnt_d = gcnt_q;
    end
  end

  // All state and registered outputs; reset drops timer_en at once so the timer clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= {SYNC_STAGES{INIT_LEVEL}};
      state_q    <= RST_STATE;
      timer_en_q <= 1'b0;
      deb_q      <= INIT_LEVEL;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      gcnt_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      timer_en_q <= timer_en_d;
      deb_q      <= deb_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      gcnt_q     <= gcnt_d;
    end
  end

  assign timer_en      = timer_en_q;
  assign debounced_out = deb_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign glitch_cnt    = gcnt_q;

endmodule
